// File: rtl/accum_sched_pkg.sv
// Shared definitions for the int64 accumulate-pipeline scheduler.
//   state_t   : scheduler FSM states (IDLE / ISSUE / DRAIN)
//   RES_W     : width of one pipeline partial result
//   SUMW_DEF  : default width of the accumulated total
//   sext_res  : sign-extends one partial to SUMW_DEF bits
package accum_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int RES_W    = 65;
  localparam int SUMW_DEF = 72;

  function automatic logic [SUMW_DEF-1:0] sext_res(input logic [RES_W-1:0] r);
    return {{(SUMW_DEF-RES_W){r[RES_W-1]}}, r};
  endfunction

endpackage

// File: rtl/accum_int64_sched_if.sv
// Bundle of every non-clock/reset signal of accum_int64_sched.
//   requester side : req_vld, req_passes -> req_rdy (one-hot grant pulse)
//   pipeline side  : din_en, sel_id, pass_idx -> ; res_en_in, res_in <-
//   result side    : out_vld, out_id, out_sum -> ; out_rdy <-
//   status         : busy, err_stray, dbg_state (FSM state)
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. req_vld/req_passes must stay stable until req_rdy;
// out_vld/out_id/out_sum stay stable until out_rdy is seen with out_vld.
// modport slave is the scheduler, modport master is its environment.
interface accum_int64_sched_if #(
  parameter int NREQ  = 4,
  parameter int PASSW = 4,
  parameter int SUMW  = 72
);
  import accum_sched_pkg::*;

  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]       req_vld;
  logic [NREQ*PASSW-1:0] req_passes;
  logic [NREQ-1:0]       req_rdy;
  logic                  din_en;
  logic [IW-1:0]         sel_id;
  logic [PASSW-1:0]      pass_idx;
  logic                  res_en_in;
  logic [RES_W-1:0]      res_in;
  logic                  out_vld;
  logic [IW-1:0]         out_id;
  logic [SUMW-1:0]       out_sum;
  logic                  out_rdy;
  logic                  busy;
  logic                  err_stray;
  state_t                dbg_state;

  modport master (
    output req_vld, req_passes, res_en_in, res_in, out_rdy,
    input  req_rdy, din_en, sel_id, pass_idx, out_vld, out_id, out_sum,
           busy, err_stray, dbg_state
  );

  modport slave (
    input  req_vld, req_passes, res_en_in, res_in, out_rdy,
    output req_rdy, din_en, sel_id, pass_idx, out_vld, out_id, out_sum,
           busy, err_stray, dbg_state
  );

endinterface

// File: rtl/accum_rr_arb.sv
// Combinational round-robin arbiter.
//   req : request vector
//   ptr : highest-priority index this cycle (pointer register lives in parent)
//   en  : grant enable; no grant when low
//   gnt : one-hot grant
//   idx : encoded index of the granted requester (0 when no grant)
module accum_rr_arb #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  int            cand;
  logic [IW-1:0] cidx;
  logic          found;

  // Scan from ptr upward with wrap; first set request wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    cidx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      cidx = IW'(cand);
      if (en && !found && req[cidx]) begin
        found     = 1'b1;
        gnt[cidx] = 1'b1;
        idx       = cidx;
      end
    end
  end

endmodule

// File: rtl/accum_int64_sched.sv
// Front-end scheduler for the shared int64 explicit-accumulate pipeline.
// Grants one requester (round-robin) a burst of P passes, issues them
// back-to-back to the pipeline, sums the P returned 65-bit partials into a
// SUMW-bit total and presents it with the requester id on a valid/ready port.
//   clk : clock, all state on the rising edge
//   rst : asynchronous active-low reset
//   bus : accum_int64_sched_if.slave (requests, pipeline, result, status)
module accum_int64_sched
  import accum_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PASSW = 4,
  parameter int SUMW  = SUMW_DEF
) (
  input logic                clk,
  input logic                rst,
  accum_int64_sched_if.slave bus
);

  localparam int IW = $clog2(NREQ);

  state_t           state, state_nxt;
  logic [IW-1:0]    rr_ptr, id_q, win_idx, rr_nxt, out_id_q;
  logic [NREQ-1:0]  gnt;
  logic [PASSW-1:0] p_q, pidx, en_cnt, rcv_cnt, win_passes;
  logic [SUMW-1:0]  acc, acc_nxt, ext, out_sum_q;
  logic             pend, out_vld_q, err_q;
  logic             gnt_en, issue_last, accept_en, stray, done;

  // Grant only when the result slot is free or draining this cycle. rst is
  // included so the combinational grant stays low while reset is held.
  assign gnt_en = rst && (state == ST_IDLE) && (|bus.req_vld) &&
                  (!out_vld_q || bus.out_rdy);

  accum_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req (bus.req_vld),
    .ptr (rr_ptr),
    .en  (gnt_en),
    .gnt (gnt),
    .idx (win_idx)
  );

  assign win_passes = bus.req_passes[int'(win_idx)*PASSW +: PASSW];
  assign rr_nxt     = (int'(win_idx) == NREQ-1) ? '0 : win_idx + IW'(1);
  assign issue_last = (state == ST_ISSUE) && (pidx == p_q - PASSW'(1));

  // en_cnt counts announced results; one beyond P (or any in IDLE) is stray.
  assign accept_en = bus.res_en_in && (state != ST_IDLE) && (en_cnt != p_q);
  assign stray     = bus.res_en_in && !accept_en;

  // pend marks that res_in carries a partial announced last cycle.
  assign ext     = SUMW'($signed(sext_res(bus.res_in)));
  assign acc_nxt = acc + ext;
  assign done    = pend && (state == ST_DRAIN) && (rcv_cnt + PASSW'(1) == p_q);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (gnt_en)     state_nxt = ST_ISSUE;
      ST_ISSUE: if (issue_last) state_nxt = ST_DRAIN;
      ST_DRAIN: if (done)       state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      id_q      <= '0;
      p_q       <= '0;
      pidx      <= '0;
      en_cnt    <= '0;
      rcv_cnt   <= '0;
      acc       <= '0;
      pend      <= 1'b0;
      err_q     <= 1'b0;
      out_vld_q <= 1'b0;
      out_id_q  <= '0;
      out_sum_q <= '0;
    end else begin
      state <= state_nxt;
      err_q <= stray;
      pend  <= accept_en;

      if (accept_en) en_cnt <= en_cnt + PASSW'(1);

      if (pend) begin
        acc     <= acc_nxt;
        rcv_cnt <= rcv_cnt + PASSW'(1);
      end

      if (gnt_en) begin
        id_q    <= win_idx;
        p_q     <= (win_passes == '0) ? PASSW'(1) : win_passes;
        acc     <= '0;
        en_cnt  <= '0;
        rcv_cnt <= '0;
        pidx    <= '0;
        rr_ptr  <= rr_nxt;
      end

      if (state == ST_ISSUE) pidx <= issue_last ? '0 : pidx + PASSW'(1);

      if (done) begin
        out_vld_q <= 1'b1;
        out_sum_q <= acc_nxt;
        out_id_q  <= id_q;
      end else if (out_vld_q && bus.out_rdy) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  assign bus.req_rdy   = gnt;
  assign bus.din_en    = (state == ST_ISSUE);
  assign bus.sel_id    = id_q;
  assign bus.pass_idx  = pidx;
  assign bus.out_vld   = out_vld_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.err_stray = err_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_accum_int64_sched.sv
// Self-checking bench for accum_int64_sched: a latency-LAT pipeline model,
// an event monitor, and one directed/randomized stimulus sequence.
module tb_accum_int64_sched;
  import accum_sched_pkg::*;

  localparam int NREQ  = 4;
  localparam int PASSW = 4;
  localparam int SUMW  = 72;
  localparam int IW    = 2;
  localparam int W     = IW + SUMW;
  localparam int LAT   = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  accum_int64_sched_if #(.NREQ(NREQ), .PASSW(PASSW), .SUMW(SUMW)) bus ();

  accum_int64_sched #(.NREQ(NREQ), .PASSW(PASSW), .SUMW(SUMW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- shared state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct { int cyc; int sel; int pidx; } issue_t;
  typedef struct { int due; logic [64:0] val; } pend_t;

  issue_t          issue_log[$];
  logic [NREQ-1:0] grant_log[$];
  logic [W-1:0]    out_log[$];
  pend_t           pq[$];
  int              grant_rd = 0;
  int              out_rd   = 0;
  int              stray_cnt = 0;
  int              stray_req = 0;
  int              stray_done = 0;
  int              pcyc = 0;
  logic [64:0]     part_tab[16];
  logic [64:0]     held;
  bit              held_v;

  function automatic logic [64:0] rand65();
    return {1'($urandom), $urandom, $urandom};
  endfunction

  // Reference: sum of the first p partials as signed integers, mod 2^SUMW.
  function automatic logic [SUMW-1:0] model_sum(input int p);
    logic signed [SUMW-1:0] s;
    s = '0;
    for (int k = 0; k < p; k++) s = s + SUMW'($signed(part_tab[k]));
    return s;
  endfunction

  // ---------------- pipeline model ----------------
  // Each din_en pass returns part_tab[pass_idx] LAT cycles later:
  // res_en_in in cycle t, data on res_in in cycle t+1, junk otherwise.
  initial begin : pipe
    bus.res_en_in = 1'b0;
    bus.res_in    = '0;
    held          = '0;
    held_v        = 1'b0;
    forever begin
      @(posedge clk); #1;
      pcyc++;
      bus.res_in = held_v ? held : rand65();
      held_v = 1'b0;
      if (bus.din_en) begin
        issue_log.push_back('{pcyc, int'(bus.sel_id), int'(bus.pass_idx)});
        pq.push_back('{pcyc + LAT, part_tab[bus.pass_idx]});
      end
      bus.res_en_in = 1'b0;
      if (pq.size() > 0 && pq[0].due == pcyc) begin
        bus.res_en_in = 1'b1;
        held   = pq[0].val;
        held_v = 1'b1;
        void'(pq.pop_front());
      end
      if (stray_req != stray_done) begin
        bus.res_en_in = 1'b1;
        stray_done++;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : mon
    forever begin
      @(negedge clk);
      if (bus.req_rdy != '0) grant_log.push_back(bus.req_rdy);
      if (bus.out_vld && bus.out_rdy) out_log.push_back({bus.out_id, bus.out_sum});
      if (bus.err_stray) stray_cnt++;
    end
  end

  // ---------------- checking / driver tasks ----------------
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_grant(output logic [NREQ-1:0] g);
    bit ok;
    ok = 1'b0;
    g  = '0;
    for (int k = 0; k < 200 && !ok; k++) begin
      tick();
      if (grant_log.size() > grant_rd) begin
        g = grant_log[grant_rd];
        grant_rd++;
        ok = 1'b1;
      end
    end
    chk("grant_wait", W'(ok), W'(1));
  endtask

  task automatic run_burst(input int id, input int p, output logic [NREQ-1:0] g);
    bus.req_passes[id*PASSW +: PASSW] = PASSW'(p);
    bus.req_vld = NREQ'(1) << id;
    wait_grant(g);
    bus.req_vld = '0;
    exp_q.push_back({IW'(id), model_sum((p == 0) ? 1 : p)});
  endtask

  task automatic check_results();
    bit got;
    while (exp_q.size() > 0) begin
      got = 1'b0;
      for (int k = 0; k < 400 && !got; k++) begin
        if (out_log.size() > out_rd) got = 1'b1;
        else tick();
      end
      chk("result_wait", W'(got), W'(1));
      if (got) begin
        chk("result", out_log[out_rd], exp_q[0]);
        out_rd++;
      end
      void'(exp_q.pop_front());
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic [NREQ-1:0] g;
    logic [NREQ-1:0] vld;
    logic [SUMW-1:0] esum;
    int i0, s0, o0, mptr, win, p;
    bit found;

    rst            = 1'b1;
    bus.req_vld    = '1;
    bus.req_passes = '0;
    bus.out_rdy    = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // reset state (requests pending to prove grant is held off)
    chk("rst_req_rdy",   W'(bus.req_rdy),   W'(0));
    chk("rst_din_en",    W'(bus.din_en),    W'(0));
    chk("rst_out_vld",   W'(bus.out_vld),   W'(0));
    chk("rst_busy",      W'(bus.busy),      W'(0));
    chk("rst_err_stray", W'(bus.err_stray), W'(0));
    chk("rst_sel_id",    W'(bus.sel_id),    W'(0));
    chk("rst_pass_idx",  W'(bus.pass_idx),  W'(0));
    chk("rst_out_id",    W'(bus.out_id),    W'(0));
    chk("rst_out_sum",   W'(bus.out_sum),   W'(0));
    chk("rst_state",     W'(bus.dbg_state), W'(ST_IDLE));
    bus.req_vld = '0;
    tick();
    rst = 1'b1;
    tick();

    // round-robin: all four requesting, one pass each
    part_tab[0] = rand65();
    for (int k = 0; k < NREQ; k++) bus.req_passes[k*PASSW +: PASSW] = PASSW'(1);
    bus.req_vld = '1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g);
      chk("rr_grant", W'(g), W'(NREQ'(1) << (k % NREQ)));
      exp_q.push_back({IW'(k % NREQ), model_sum(1)});
    end
    bus.req_vld = '0;
    check_results();

    // single request: id 2, partials 5, -2, 10
    part_tab[0] = 65'd5;
    part_tab[1] = -65'sd2;
    part_tab[2] = 65'd10;
    i0 = issue_log.size();
    run_burst(2, 3, g);
    chk("t1_grant", W'(g), W'(4'b0100));
    check_results();
    chk("t1_out", out_log[out_rd-1], {2'd2, 72'd13});
    chk("t1_issue_cnt", W'(issue_log.size() - i0), W'(3));
    for (int k = 0; k < 3; k++) begin
      chk("t1_sel", W'(issue_log[i0+k].sel), W'(2));
      chk("t1_pidx", W'(issue_log[i0+k].pidx), W'(k));
      if (k > 0) chk("t1_consec", W'(issue_log[i0+k].cyc - issue_log[i0+k-1].cyc), W'(1));
    end

    // backpressure: result held, pending request waits, then grant on drain
    for (int k = 0; k < 16; k++) part_tab[k] = rand65();
    bus.out_rdy = 1'b0;
    run_burst(0, 2, g);
    chk("bp_grant0", W'(g), W'(4'b0001));
    esum = model_sum(2);
    bus.req_passes[1*PASSW +: PASSW] = PASSW'(1);
    bus.req_vld = 4'b0010;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (bus.out_vld) found = 1'b1;
      else tick();
    end
    chk("bp_vld_wait", W'(found), W'(1));
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_vld", W'(bus.out_vld), W'(1));
      chk("bp_hold_sum", W'(bus.out_sum), W'(esum));
      chk("bp_no_grant", W'(grant_log.size()), W'(grant_rd));
    end
    bus.out_rdy = 1'b1;
    @(negedge clk);
    chk("bp_grant_on_drain", W'(bus.req_rdy), W'(4'b0010));
    chk("bp_vld_on_drain", W'(bus.out_vld), W'(1));
    wait_grant(g);
    bus.req_vld = '0;
    exp_q.push_back({IW'(1), model_sum(1)});
    check_results();

    // wrap: 15 passes of -1
    for (int k = 0; k < 16; k++) part_tab[k] = '1;
    i0 = issue_log.size();
    run_burst(3, 15, g);
    check_results();
    chk("wrap_sum", out_log[out_rd-1], {2'd3, 72'hFF_FFFF_FFFF_FFFF_FFF1});
    chk("wrap_issue_cnt", W'(issue_log.size() - i0), W'(15));

    // stray result while idle
    s0 = stray_cnt;
    o0 = out_log.size();
    stray_req++;
    repeat (4) tick();
    chk("stray_pulse", W'(stray_cnt - s0), W'(1));
    chk("stray_no_out", W'(out_log.size()), W'(o0));
    chk("stray_vld", W'(bus.out_vld), W'(0));
    chk("stray_busy", W'(bus.busy), W'(0));

    // passes = 0 behaves as one pass
    part_tab[0] = rand65();
    i0 = issue_log.size();
    s0 = stray_cnt;
    run_burst(1, 0, g);
    check_results();
    chk("p0_issue_cnt", W'(issue_log.size() - i0), W'(1));
    chk("p0_pidx", W'(issue_log[i0].pidx), W'(0));
    chk("p0_no_stray", W'(stray_cnt - s0), W'(0));

    // async reset in the middle of ISSUE (pass 1 of 4)
    for (int k = 0; k < 16; k++) part_tab[k] = rand65();
    bus.req_passes[1*PASSW +: PASSW] = PASSW'(4);
    bus.req_vld = 4'b0010;
    wait_grant(g);
    bus.req_vld = '0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (bus.din_en && bus.pass_idx == PASSW'(1)) found = 1'b1;
      else tick();
    end
    chk("mid_reach_pass1", W'(found), W'(1));
    #2 rst = 1'b0;
    #1;
    chk("mid_req_rdy",   W'(bus.req_rdy),   W'(0));
    chk("mid_din_en",    W'(bus.din_en),    W'(0));
    chk("mid_out_vld",   W'(bus.out_vld),   W'(0));
    chk("mid_busy",      W'(bus.busy),      W'(0));
    chk("mid_err_stray", W'(bus.err_stray), W'(0));
    chk("mid_sel_id",    W'(bus.sel_id),    W'(0));
    chk("mid_pass_idx",  W'(bus.pass_idx),  W'(0));
    chk("mid_out_id",    W'(bus.out_id),    W'(0));
    chk("mid_out_sum",   W'(bus.out_sum),   W'(0));
    chk("mid_state",     W'(bus.dbg_state), W'(ST_IDLE));
    s0 = stray_cnt;
    o0 = out_log.size();
    tick();
    rst = 1'b1;
    repeat (12) tick();
    chk("mid_late_strays", W'(stray_cnt - s0), W'(2));
    chk("mid_no_out", W'(out_log.size()), W'(o0));
    run_burst(1, 2, g);
    chk("mid_next_grant", W'(g), W'(4'b0010));
    check_results();

    // randomized bursts against the round-robin rule and sum model
    mptr = 2;
    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < 16; k++) part_tab[k] = rand65();
      vld = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int k = 0; k < NREQ; k++) bus.req_passes[k*PASSW +: PASSW] = PASSW'($urandom_range(0, 15));
      win = -1;
      for (int k = 0; k < NREQ; k++)
        if (win < 0 && vld[(mptr + k) % NREQ]) win = (mptr + k) % NREQ;
      p = int'(bus.req_passes[win*PASSW +: PASSW]);
      bus.req_vld = vld;
      wait_grant(g);
      bus.req_vld = '0;
      chk("rand_grant", W'(g), W'(NREQ'(1) << win));
      exp_q.push_back({IW'(win), model_sum((p == 0) ? 1 : p)});
      mptr = (win + 1) % NREQ;
      check_results();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
